// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// mem_access_unit_pkg : size codes, FSM states and lane helpers for the LSU
// Revision 1.0
// ============================================================================
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SZ_B:    return 1'b1;
      SZ_H:    return off[0] == 1'b0;
      SZ_W:    return off[1:0] == 2'b00;
      default: return off == 3'b000;
    endcase
  endfunction

  // Byte lanes touched by an access of the given size, starting at lane 0.
  function automatic logic [7:0] lane_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_lane_align.sv
`default_nettype none
// ============================================================================
// lane_align : shifts data between right-justified and 8-byte bus lane form
// Revision 1.0
// ============================================================================
module lane_align
  import mem_access_unit_pkg::*;
#(
  parameter bit LOAD = 1'b0
) (
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic [63:0] din,
  output logic [63:0] dout,
  output logic [7:0]  strb
);

  logic [5:0] shamt;
  logic [7:0] bmask;

  assign shamt = {off, 3'b000};
  assign bmask = lane_mask(size);

  if (LOAD) begin : g_load
    logic [63:0] dmask;

    always_comb begin
      dmask = '0;
      for (int i = 0; i < 8; i++) begin
        dmask[8*i +: 8] = {8{bmask[i]}};
      end
    end

    // Loads enable no write lanes.
    assign dout = (din >> shamt) & dmask;
    assign strb = 8'h00;
  end else begin : g_store
    assign dout = din << shamt;
    assign strb = bmask << off;
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : load/store unit driving a valid/ready data-memory bus
// Revision 1.0
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic              st_en,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       st_data,
  output logic [63:0]       mem_rd_data,
  output logic              stall,
  output logic              misalign,
  output logic              acc_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [63:0]       bus_wdata,
  output logic [7:0]        bus_wstrb,
  input  logic              bus_resp_valid,
  input  logic [63:0]       bus_rdata,
  input  logic              bus_resp_err
);

  state_t      state;
  logic [2:0]  off_r;
  logic [1:0]  size_r;
  logic        req;
  logic        aligned;
  logic        start;
  logic [63:0] st_wdata;
  logic [7:0]  st_strb;
  logic [63:0] ld_data;
  logic [7:0]  ld_strb;

  assign req      = ld_en | st_en;
  assign aligned  = is_aligned(size, addr[2:0]);
  assign start    = (state == ST_IDLE) & req & aligned;
  assign misalign = (state == ST_IDLE) & req & ~aligned;
  assign stall    = start | (state == ST_REQ) | (state == ST_RESP);

  lane_align #(.LOAD(1'b0)) u_store_lane (
    .off  (addr[2:0]),
    .size (size),
    .din  (st_data),
    .dout (st_wdata),
    .strb (st_strb)
  );

  lane_align #(.LOAD(1'b1)) u_load_lane (
    .off  (off_r),
    .size (size_r),
    .din  (bus_rdata),
    .dout (ld_data),
    .strb (ld_strb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      off_r         <= '0;
      size_r        <= '0;
      mem_rd_data   <= '0;
      acc_err       <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_wstrb     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // A simultaneous ld_en/st_en is treated as a load.
            state         <= ST_REQ;
            bus_req_valid <= 1'b1;
            bus_we        <= ~ld_en;
            bus_addr      <= {addr[ADDR_W-1:3], 3'b000};
            bus_wdata     <= st_wdata;
            bus_wstrb     <= ld_en ? ld_strb : st_strb;
            off_r         <= addr[2:0];
            size_r        <= size;
          end
        end
        ST_REQ: begin
          if (bus_req_ready) begin
            state         <= ST_RESP;
            bus_req_valid <= 1'b0;
          end
        end
        ST_RESP: begin
          if (bus_resp_valid) begin
            state       <= ST_DONE;
            mem_rd_data <= bus_resp_err ? 64'd0 : ld_data;
            acc_err     <= bus_resp_err;
          end
        end
        default: begin
          state       <= ST_IDLE;
          mem_rd_data <= '0;
          acc_err     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_access_unit : directed and randomized checks against a byte-lane model
// Revision 1.0
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en, st_en;
  logic [1:0]  size;
  logic [63:0] addr, st_data;
  logic [63:0] mem_rd_data;
  logic        stall, misalign, acc_err;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [63:0] bus_addr, bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_resp_valid, bus_resp_err;
  logic [63:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ADDR_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .ld_en          (ld_en),
    .st_en          (st_en),
    .size           (size),
    .addr           (addr),
    .st_data        (st_data),
    .mem_rd_data    (mem_rd_data),
    .stall          (stall),
    .misalign       (misalign),
    .acc_err        (acc_err),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_wstrb      (bus_wstrb),
    .bus_resp_valid (bus_resp_valid),
    .bus_rdata      (bus_rdata),
    .bus_resp_err   (bus_resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain byte arithmetic on a little-endian 8-byte word.
  function automatic bit ref_aligned(input logic [1:0] sz, input logic [63:0] a);
    return (a % (64'd1 << sz)) == 64'd0;
  endfunction

  function automatic logic [7:0] ref_strb(input logic [1:0] sz, input logic [2:0] off);
    int nb;
    logic [15:0] m;
    nb = 1 << sz;
    m  = 16'(((1 << nb) - 1) << off);
    return m[7:0];
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] rd, input logic [1:0] sz,
                                           input logic [2:0] off);
    logic [63:0] v;
    int nb;
    v  = rd >> (8 * off);
    nb = 1 << sz;
    if (nb < 8) v = v % (64'd1 << (8 * nb));
    return v;
  endfunction

  // Runs one instruction from its IDLE cycle to the cycle after DONE.
  task automatic access(input bit ld, input bit st, input logic [1:0] sz, input logic [63:0] a,
                        input logic [63:0] sd, input logic [63:0] rd, input int rdy_dly,
                        input int rsp_dly, input bit err);
    bit active;
    bit al;
    int stalls;
    logic [2:0] off;
    active = ld | st;
    al     = ref_aligned(sz, a);
    off    = a[2:0];
    stalls = 0;
    ld_en = ld; st_en = st; size = sz; addr = a; st_data = sd;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    #1;
    check("idle_misalign", 64'(misalign), 64'(active && !al));
    check("idle_stall", 64'(stall), 64'(active && al));
    check("idle_rd_data", mem_rd_data, 64'd0);
    if (stall) stalls++;
    if (!active || !al) begin
      @(posedge clk);
      ld_en = 1'b0; st_en = 1'b0;
      #1;
      check("noreq_valid", 64'(bus_req_valid), 64'd0);
      check("noreq_stall", 64'(stall), 64'd0);
      return;
    end
    @(posedge clk); #1;
    for (int k = 0; k <= rdy_dly; k++) begin
      check("req_valid", 64'(bus_req_valid), 64'd1);
      check("req_stall", 64'(stall), 64'd1);
      check("req_addr", bus_addr, {a[63:3], 3'b000});
      check("req_we", 64'(bus_we), 64'(!ld));
      check("req_wstrb", 64'(bus_wstrb), ld ? 64'd0 : 64'(ref_strb(sz, off)));
      if (!ld) check("req_wdata", bus_wdata, sd << (8 * off));
      if (stall) stalls++;
      bus_req_ready  = (k == rdy_dly);
      bus_resp_valid = 1'($urandom_range(0, 1));
      bus_rdata      = {$urandom, $urandom};
      bus_resp_err   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus_req_ready = 1'b0;
    for (int k = 0; k <= rsp_dly; k++) begin
      check("resp_stall", 64'(stall), 64'd1);
      check("resp_valid_low", 64'(bus_req_valid), 64'd0);
      if (stall) stalls++;
      bus_resp_valid = (k == rsp_dly);
      bus_rdata      = (k == rsp_dly) ? rd : {$urandom, $urandom};
      bus_resp_err   = (k == rsp_dly) ? err : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus_resp_valid = 1'($urandom_range(0, 1));
    bus_rdata      = {$urandom, $urandom};
    check("done_stall", 64'(stall), 64'd0);
    check("stall_cycles", 64'(stalls), 64'(3 + rdy_dly + rsp_dly));
    check("done_rd_data", mem_rd_data, err ? 64'd0 : ref_load(rd, sz, off));
    check("done_acc_err", 64'(acc_err), 64'(err));
    check("done_misalign", 64'(misalign), 64'd0);
    @(posedge clk);
    ld_en = 1'b0; st_en = 1'b0; bus_resp_valid = 1'b0;
    #1;
    check("after_rd_data", mem_rd_data, 64'd0);
    check("after_acc_err", 64'(acc_err), 64'd0);
    check("after_stall", 64'(stall), 64'd0);
  endtask

  bit          r_ld, r_st, r_err;
  logic [1:0]  r_sz;
  logic [63:0] r_addr;

  initial begin
    rst = 1'b1; ld_en = 1'b0; st_en = 1'b0; size = 2'b00; addr = '0; st_data = '0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = '0; bus_resp_err = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_rd_data", mem_rd_data, 64'd0);
    check("reset_valid", 64'(bus_req_valid), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_wstrb", 64'(bus_wstrb), 64'd0);
    check("reset_addr", bus_addr, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    access(1'b1, 1'b0, 2'b11, 64'h1000, 64'd0, 64'h1122334455667788, 0, 0, 1'b0);
    access(1'b1, 1'b0, 2'b00, 64'h1003, 64'd0, 64'h1122334455667788, 0, 0, 1'b0);
    access(1'b0, 1'b1, 2'b01, 64'h2006, 64'hABCD, 64'd0, 0, 1, 1'b0);
    access(1'b1, 1'b0, 2'b10, 64'h1002, 64'd0, 64'd0, 0, 0, 1'b0);
    access(1'b1, 1'b0, 2'b11, 64'h3000, 64'd0, 64'hDEADBEEFCAFEF00D, 5, 0, 1'b1);
    access(1'b1, 1'b1, 2'b10, 64'h4004, 64'h55, 64'h8877665544332211, 1, 2, 1'b0);
    access(1'b0, 1'b1, 2'b11, 64'h5003, 64'h1, 64'd0, 0, 0, 1'b0);

    // Asynchronous reset while waiting for a response.
    ld_en = 1'b1; st_en = 1'b0; size = 2'b11; addr = 64'h4008; bus_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    check("rst_pre_stall", 64'(stall), 64'd1);
    #1;
    rst = 1'b1; ld_en = 1'b0;
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_valid", 64'(bus_req_valid), 64'd0);
    check("rst_addr", bus_addr, 64'd0);
    check("rst_we", 64'(bus_we), 64'd0);
    check("rst_wdata", bus_wdata, 64'd0);
    check("rst_rd_data", mem_rd_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_resp_valid = 1'b1; bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF; bus_resp_err = 1'b1;
    @(posedge clk); #1;
    bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
    check("post_rst_stall", 64'(stall), 64'd0);
    check("post_rst_rd_data", mem_rd_data, 64'd0);
    check("post_rst_acc_err", 64'(acc_err), 64'd0);
    access(1'b1, 1'b0, 2'b11, 64'h4008, 64'd0, 64'h0123456789ABCDEF, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r_ld   = 1'($urandom_range(0, 1));
      r_st   = !r_ld || ($urandom_range(0, 3) == 0);
      r_sz   = 2'($urandom_range(0, 3));
      r_addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((64'd1 << r_sz) - 64'd1);
      r_err  = ($urandom_range(0, 7) == 0);
      access(r_ld, r_st, r_sz, r_addr, {$urandom, $urandom},
             r_ld ? {$urandom, $urandom} : 64'd0,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
